// File: rtl/spi_byte_rx_if.sv
// Bundle of SPI-side inputs and receive-FIFO consumer signals for spi_byte_rx.
// frame_len is present only when SPI_RX_FRAME_LEN_EN is defined.
interface spi_byte_rx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                  spi_clk_in;
   logic                  spi_sel_in;
   logic [DATA_WIDTH-1:0] spi_data_in;
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_last;
   logic                  rx_ready;
   logic [CNT_W-1:0]      fifo_count;
   logic                  frame_done;
   logic                  overflow;
   logic                  ovf_clr;
`ifdef SPI_RX_FRAME_LEN_EN
   logic [7:0]            frame_len;

   modport slave (
      input  spi_clk_in, spi_sel_in, spi_data_in, rx_ready, ovf_clr,
      output rx_valid, rx_data, rx_last, fifo_count, frame_done, overflow, frame_len
   );
   modport master (
      output spi_clk_in, spi_sel_in, spi_data_in, rx_ready, ovf_clr,
      input  rx_valid, rx_data, rx_last, fifo_count, frame_done, overflow, frame_len
   );
`else
   modport slave (
      input  spi_clk_in, spi_sel_in, spi_data_in, rx_ready, ovf_clr,
      output rx_valid, rx_data, rx_last, fifo_count, frame_done, overflow
   );
   modport master (
      output spi_clk_in, spi_sel_in, spi_data_in, rx_ready, ovf_clr,
      input  rx_valid, rx_data, rx_last, fifo_count, frame_done, overflow
   );
`endif
endinterface

// File: rtl/spi_byte_rx.sv
// Synchronizing SPI word receiver with a one-word staging register and a first-word fall-through FIFO.
// Optional feature: define SPI_RX_FRAME_LEN_EN to add the saturating frame_len capture counter.
module spi_byte_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic         clk,
   input logic         rst,
   spi_byte_rx_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, FLUSH} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0]                 clkSync_q, selSync_q;
   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] dataSync_q;
   logic                                   clkPrev_q;
   logic                                   clkS, selS;
   logic [DATA_WIDTH-1:0]                  dataS;

   logic [DATA_WIDTH-1:0] staged_q, staged_d;
   logic                  stagedValid_q, stagedValid_d;
   logic                  capture, flush, push;
   logic [DATA_WIDTH:0]   pushWord;

   logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  frameDone_q;
   logic                  full, pop, pushOk, drop;
   logic [DATA_WIDTH:0]   head;

   assign clkS  = clkSync_q[SYNC_STAGES-1];
   assign selS  = selSync_q[SYNC_STAGES-1];
   assign dataS = dataSync_q[SYNC_STAGES-1];

   // All three inputs travel through the same depth so data lines up with its clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkSync_q  <= '0;
         selSync_q  <= '0;
         dataSync_q <= '0;
         clkPrev_q  <= 1'b0;
      end else begin
         clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], bus.spi_clk_in};
         selSync_q  <= {selSync_q[SYNC_STAGES-2:0], bus.spi_sel_in};
         dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], bus.spi_data_in};
         clkPrev_q  <= clkS;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= WAIT_IDLE;
         staged_q      <= '0;
         stagedValid_q <= 1'b0;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         frameDone_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         staged_q      <= staged_d;
         stagedValid_q <= stagedValid_d;
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         frameDone_q   <= flush;
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      flush   = 1'b0;
      case (state_q)
         WAIT_IDLE: if (selS) state_d = IDLE;
         IDLE:      if (!selS) state_d = ACTIVE;
         ACTIVE: begin
            capture = clkS & ~clkPrev_q & ~selS;
            if (selS) state_d = FLUSH;
         end
         FLUSH: begin
            flush   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   // A word is only known to be non-final once the next one arrives, hence the staging slot.
   always_comb begin
      staged_d      = staged_q;
      stagedValid_d = stagedValid_q;
      push          = 1'b0;
      pushWord      = {1'b0, staged_q};
      if (capture) begin
         staged_d      = dataS;
         stagedValid_d = 1'b1;
         push          = stagedValid_q;
      end else if (flush) begin
         staged_d      = '0;
         stagedValid_d = 1'b0;
         push          = stagedValid_q;
         pushWord      = {1'b1, staged_q};
      end
   end

   assign full   = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop    = (count_q != '0) && bus.rx_ready;
   assign pushOk = push && (!full || pop);
   assign drop   = push && full && !pop;

   always_comb begin
      wrPtr_d    = wrPtr_q + PTR_W'(pushOk);
      rdPtr_d    = rdPtr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(pushOk) - CNT_W'(pop);
      overflow_d = overflow_q;
      if (drop)             overflow_d = 1'b1;
      else if (bus.ovf_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr_q] <= pushWord;
   end

   // Head is gated so an empty FIFO presents zeros rather than stale or unwritten storage.
   assign head           = mem[rdPtr_q];
   assign bus.rx_valid   = (count_q != '0);
   assign bus.rx_data    = bus.rx_valid ? head[DATA_WIDTH-1:0] : '0;
   assign bus.rx_last    = bus.rx_valid ? head[DATA_WIDTH] : 1'b0;
   assign bus.fifo_count = count_q;
   assign bus.frame_done = frameDone_q;
   assign bus.overflow   = overflow_q;

`ifdef SPI_RX_FRAME_LEN_EN
   logic [7:0] frameCnt_q, frameCnt_d, frameLen_q, frameLen_d;

   always_comb begin
      frameCnt_d = frameCnt_q;
      frameLen_d = frameLen_q;
      if (flush) begin
         frameLen_d = frameCnt_q;
         frameCnt_d = '0;
      end else if (capture && frameCnt_q != 8'hFF) begin
         frameCnt_d = frameCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frameCnt_q <= '0;
         frameLen_q <= '0;
      end else begin
         frameCnt_q <= frameCnt_d;
         frameLen_q <= frameLen_d;
      end
   end

   assign bus.frame_len = frameLen_q;
`endif
endmodule

// File: tb/tb_spi_byte_rx.sv
// Scoreboard bench for spi_byte_rx: expected FIFO words are queued as SPI words are driven.
module tb_spi_byte_rx;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int SS    = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   doneTotal   = 0;
   logic [DW:0] expQ [$];

   spi_byte_rx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   spi_byte_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.frame_done === 1'b1) doneTotal++;

   task automatic applyStimulus(input logic [DW-1:0] w);
      @(negedge clk);
      bus.spi_data_in = w;
      bus.spi_clk_in  = 1'b0;
      @(negedge clk);
      bus.spi_clk_in  = 1'b1;
   endtask

   task automatic startFrame();
      @(negedge clk);
      bus.spi_sel_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic endFrame();
      @(negedge clk);
      bus.spi_clk_in = 1'b0;
      repeat (2) @(negedge clk);
      bus.spi_sel_in = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      testsRun++; if (bus.rx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
      testsRun++; if (bus.rx_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
      testsRun++; if (bus.rx_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rx_last: got %b expected 0", bus.rx_last); end
      testsRun++; if (bus.fifo_count !== '0) begin testsFailed++; $display("[TB] FAIL reset_fifo_count: got %0d expected 0", bus.fifo_count); end
      testsRun++; if (bus.frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
      testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
`ifdef SPI_RX_FRAME_LEN_EN
      testsRun++; if (bus.frame_len !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_frame_len: got %0d expected 0", bus.frame_len); end
`endif
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_host_frame();
      int startDone;
      int received;
      startDone = doneTotal;
      received  = 0;
      expQ.delete();
      bus.rx_ready = 1'b1;
      fork
         begin
            startFrame();
            for (int w = 1; w <= 14; w++) begin
               expQ.push_back({(w == 14), DW'(w)});
               applyStimulus(DW'(w));
            end
            endFrame();
         end
         begin
            for (int c = 0; c < 80; c++) begin
               @(negedge clk);
               if (bus.rx_valid === 1'b1) begin
                  received++;
                  testsRun++;
                  if (expQ.size() == 0) begin
                     testsFailed++;
                     $display("[TB] FAIL host_extra_word: got last=%b data=%h expected no word", bus.rx_last, bus.rx_data);
                  end else begin
                     if ({bus.rx_last, bus.rx_data} !== expQ[0]) begin
                        testsFailed++;
                        $display("[TB] FAIL host_word: got last=%b data=%h expected last=%b data=%h",
                                 bus.rx_last, bus.rx_data, expQ[0][DW], expQ[0][DW-1:0]);
                     end
                     void'(expQ.pop_front());
                  end
               end
            end
         end
      join
      bus.rx_ready = 1'b0;
      testsRun++; if (received != 14) begin testsFailed++; $display("[TB] FAIL host_word_count: got %0d expected 14", received); end
      testsRun++; if (doneTotal - startDone != 1) begin testsFailed++; $display("[TB] FAIL host_frame_done: got %0d pulses expected 1", doneTotal - startDone); end
`ifdef SPI_RX_FRAME_LEN_EN
      testsRun++; if (bus.frame_len !== 8'd14) begin testsFailed++; $display("[TB] FAIL host_frame_len: got %0d expected 14", bus.frame_len); end
`endif
   endtask

   task automatic test_overflow();
      expQ.delete();
      bus.rx_ready = 1'b0;
      startFrame();
      for (int w = 1; w <= 20; w++) begin
         if (w <= DEPTH) expQ.push_back({1'b0, DW'(w)});
         applyStimulus(DW'(w));
      end
      endFrame();
      testsRun++; if (bus.fifo_count !== CW'(DEPTH)) begin testsFailed++; $display("[TB] FAIL ovf_fifo_count: got %0d expected %0d", bus.fifo_count, DEPTH); end
      testsRun++; if (bus.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_flag: got %b expected 1", bus.overflow); end
`ifdef SPI_RX_FRAME_LEN_EN
      testsRun++; if (bus.frame_len !== 8'd20) begin testsFailed++; $display("[TB] FAIL ovf_frame_len: got %0d expected 20", bus.frame_len); end
`endif
      bus.rx_ready = 1'b1;
      for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
         if (bus.rx_valid === 1'b1) begin
            testsRun++;
            if ({bus.rx_last, bus.rx_data} !== expQ[0]) begin
               testsFailed++;
               $display("[TB] FAIL ovf_drain: got last=%b data=%h expected last=%b data=%h",
                        bus.rx_last, bus.rx_data, expQ[0][DW], expQ[0][DW-1:0]);
            end
            void'(expQ.pop_front());
         end
         @(negedge clk);
      end
      bus.rx_ready = 1'b0;
      testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL ovf_drain_timeout: got %0d words left expected 0", expQ.size()); end
      testsRun++; if (bus.fifo_count !== '0) begin testsFailed++; $display("[TB] FAIL ovf_after_drain: got %0d expected 0", bus.fifo_count); end
   endtask

   task automatic test_ovf_clr();
      expQ.delete();
      @(negedge clk); bus.ovf_clr = 1'b1;
      @(negedge clk); bus.ovf_clr = 1'b0;
      testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_idle: got %b expected 0", bus.overflow); end
      startFrame();
      for (int w = 1; w <= 17; w++) begin
         if (w <= DEPTH) expQ.push_back({1'b0, DW'(w)});
         applyStimulus(DW'(w));
      end
      repeat (3) @(negedge clk);
      testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_before_drop: got %b expected 0", bus.overflow); end
      applyStimulus(DW'(18));
      repeat (SS) @(negedge clk);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      testsRun++; if (bus.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL clr_set_wins: got %b expected 1", bus.overflow); end
      @(negedge clk); bus.ovf_clr = 1'b1;
      @(negedge clk); bus.ovf_clr = 1'b0;
      testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_no_push: got %b expected 0", bus.overflow); end
      endFrame();
      testsRun++; if (bus.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL clr_flush_drop: got %b expected 1", bus.overflow); end
      bus.rx_ready = 1'b1;
      for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
         if (bus.rx_valid === 1'b1) begin
            testsRun++;
            if ({bus.rx_last, bus.rx_data} !== expQ[0]) begin
               testsFailed++;
               $display("[TB] FAIL clr_drain: got last=%b data=%h expected last=%b data=%h",
                        bus.rx_last, bus.rx_data, expQ[0][DW], expQ[0][DW-1:0]);
            end
            void'(expQ.pop_front());
         end
         @(negedge clk);
      end
      bus.rx_ready = 1'b0;
      testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL clr_drain_timeout: got %0d words left expected 0", expQ.size()); end
      bus.ovf_clr = 1'b1;
      @(negedge clk); bus.ovf_clr = 1'b0;
      testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_final: got %b expected 0", bus.overflow); end
   endtask

   task automatic test_full_push_pop();
      expQ.delete();
      bus.rx_ready = 1'b0;
      startFrame();
      for (int w = 1; w <= 17; w++) begin
         expQ.push_back({1'b0, DW'(w)});
         applyStimulus(DW'(w));
      end
      repeat (3) @(negedge clk);
      testsRun++; if (bus.fifo_count !== CW'(DEPTH)) begin testsFailed++; $display("[TB] FAIL full_fill: got %0d expected %0d", bus.fifo_count, DEPTH); end
      applyStimulus(DW'(18));
      repeat (SS) @(negedge clk);
      testsRun++;
      if ({bus.rx_last, bus.rx_data} !== expQ[0]) begin
         testsFailed++;
         $display("[TB] FAIL full_pop_head: got last=%b data=%h expected last=%b data=%h",
                  bus.rx_last, bus.rx_data, expQ[0][DW], expQ[0][DW-1:0]);
      end
      void'(expQ.pop_front());
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      testsRun++; if (bus.fifo_count !== CW'(DEPTH)) begin testsFailed++; $display("[TB] FAIL full_push_pop_count: got %0d expected %0d", bus.fifo_count, DEPTH); end
      testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_push_pop_ovf: got %b expected 0", bus.overflow); end
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            endFrame();
            expQ.push_back({1'b1, DW'(18)});
         end
         bus.rx_ready = 1'b1;
         for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
            if (bus.rx_valid === 1'b1) begin
               testsRun++;
               if ({bus.rx_last, bus.rx_data} !== expQ[0]) begin
                  testsFailed++;
                  $display("[TB] FAIL full_drain: got last=%b data=%h expected last=%b data=%h",
                           bus.rx_last, bus.rx_data, expQ[0][DW], expQ[0][DW-1:0]);
               end
               void'(expQ.pop_front());
            end
            @(negedge clk);
         end
         bus.rx_ready = 1'b0;
         testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL full_drain_timeout: got %0d words left expected 0", expQ.size()); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int startDone;
      expQ.delete();
      bus.rx_ready = 1'b0;
      startFrame();
      for (int w = 1; w <= 5; w++) applyStimulus(DW'(w));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      testsRun++;
      if ({bus.rx_valid, bus.rx_data, bus.rx_last, bus.fifo_count, bus.frame_done, bus.overflow} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL midrst_outputs: got valid=%b data=%h last=%b count=%0d done=%b ovf=%b expected all 0",
                  bus.rx_valid, bus.rx_data, bus.rx_last, bus.fifo_count, bus.frame_done, bus.overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      startDone = doneTotal;
      for (int w = 6; w <= 8; w++) applyStimulus(DW'(w));
      endFrame();
      testsRun++; if (bus.fifo_count !== '0) begin testsFailed++; $display("[TB] FAIL midrst_ignored: got %0d expected 0", bus.fifo_count); end
      testsRun++; if (doneTotal - startDone != 0) begin testsFailed++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", doneTotal - startDone); end
      startFrame();
      for (int w = 21; w <= 23; w++) begin
         expQ.push_back({(w == 23), DW'(w)});
         applyStimulus(DW'(w));
      end
      endFrame();
      testsRun++; if (bus.fifo_count !== CW'(3)) begin testsFailed++; $display("[TB] FAIL midrst_next_count: got %0d expected 3", bus.fifo_count); end
      bus.rx_ready = 1'b1;
      for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
         if (bus.rx_valid === 1'b1) begin
            testsRun++;
            if ({bus.rx_last, bus.rx_data} !== expQ[0]) begin
               testsFailed++;
               $display("[TB] FAIL midrst_drain: got last=%b data=%h expected last=%b data=%h",
                        bus.rx_last, bus.rx_data, expQ[0][DW], expQ[0][DW-1:0]);
            end
            void'(expQ.pop_front());
         end
         @(negedge clk);
      end
      bus.rx_ready = 1'b0;
      testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL midrst_drain_timeout: got %0d words left expected 0", expQ.size()); end
   endtask

   task automatic test_empty_frame();
      int startDone;
      startDone = doneTotal;
      startFrame();
      endFrame();
      testsRun++; if (doneTotal - startDone != 1) begin testsFailed++; $display("[TB] FAIL empty_frame_done: got %0d pulses expected 1", doneTotal - startDone); end
      testsRun++; if (bus.fifo_count !== '0) begin testsFailed++; $display("[TB] FAIL empty_fifo_count: got %0d expected 0", bus.fifo_count); end
`ifdef SPI_RX_FRAME_LEN_EN
      testsRun++; if (bus.frame_len !== 8'd0) begin testsFailed++; $display("[TB] FAIL empty_frame_len: got %0d expected 0", bus.frame_len); end
`endif
   endtask

   initial begin
      bus.spi_clk_in  = 1'b0;
      bus.spi_sel_in  = 1'b1;
      bus.spi_data_in = '0;
      bus.rx_ready    = 1'b0;
      bus.ovf_clr     = 1'b0;
      test_reset();
      test_host_frame();
      test_overflow();
      test_ovf_clr();
      test_full_push_pop();
      test_reset_mid_frame();
      test_empty_frame();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one transferred word (one word per spi_clk period).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of receive FIFO entries, a power of two and at least 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops, at least 2.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 spi_clk_in  input  1  SPI clock from the host's clk_out, asynchronous to clk.
REQ-007 spi_sel_in  input  1  select from the host's sel_out, active-low (0 = frame active).
REQ-008 spi_data_in  input  DATA_WIDTH  parallel word from the host's data_out.
REQ-009 rx_valid  output  1  FIFO head word is valid.
REQ-010 rx_data  output  DATA_WIDTH  FIFO head word.
REQ-011 rx_last  output  1  FIFO head word is the last word of its frame.
REQ-012 rx_ready  input  1  consumer accepts the head word when rx_valid and rx_ready are both 1.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-015 overflow  output  1  sticky flag: a word was dropped.
REQ-016 ovf_clr  input  1  clears overflow.

Function
REQ-017 SHALL pass spi_clk_in, spi_sel_in and spi_data_in through SYNC_STAGES flops each, with all three aligned to the same depth.
REQ-018 SHALL detect a capture event as a synchronized spi_clk 0->1 transition while synchronized sel = 0 and state = ACTIVE.
REQ-019 SHALL implement states WAIT_IDLE, IDLE, ACTIVE and FLUSH.
REQ-020 WAIT_IDLE -> IDLE when synchronized sel = 1.
REQ-021 IDLE -> ACTIVE when synchronized sel = 0.
REQ-022 ACTIVE -> FLUSH when synchronized sel = 1.
REQ-023 FLUSH -> IDLE after exactly one cycle.
REQ-024 On a capture event, SHALL load the synchronized data into a one-word staging register; if the staging register already held a word, that older word SHALL be pushed to the FIFO with last = 0 in the same cycle.
REQ-025 In FLUSH, SHALL push the staged word (if any) with last = 1, empty the staging register, and pulse frame_done.
REQ-026 A frame with zero captures SHALL still pulse frame_done but SHALL push nothing.
REQ-027 FIFO words SHALL be DATA_WIDTH+1 bits wide (data plus last).
REQ-028 rx_data and rx_last SHALL be combinational from the head entry (first-word fall-through).
REQ-029 rx_valid SHALL equal (fifo_count != 0).
REQ-030 A push when fifo_count = FIFO_DEPTH and no pop occurs in that cycle SHALL drop the word and set overflow.
REQ-031 A push and a pop in the same cycle when full SHALL both succeed, leaving fifo_count unchanged.
REQ-032 A push and a pop in the same cycle when empty SHALL leave the pushed word available on the next cycle; a pop SHALL NOT occur while empty.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 ovf_clr SHALL clear overflow on the next cycle; if ovf_clr coincides with a dropping push, overflow SHALL stay 1 (set wins).
REQ-035 Latency from the synchronized spi_clk rising edge to the earliest possible rx_valid for the previous word SHALL be 1 clk.

Reset
REQ-036 rst SHALL asynchronously clear all synchronizers, the staging register, the FIFO pointers, fifo_count, overflow, frame_done, and (when compiled in) frame_len.
REQ-037 After reset, outputs SHALL be rx_valid = 0, rx_data = 0, rx_last = 0, fifo_count = 0, frame_done = 0, overflow = 0.
REQ-038 State SHALL reset to WAIT_IDLE, so that a frame already in progress at reset release is ignored until sel returns high.

Configuration
REQ-039 With SPI_RX_FRAME_LEN_EN defined, SHALL add output frame_len (8 bits), which counts the captures of the current frame, saturates at 255, is updated on frame_done, and holds until the next frame_done.
REQ-040 Without SPI_RX_FRAME_LEN_EN, SHALL have no frame_len port and no counter logic.

Verification
REQ-041 Host-style frame: sel low, words 1..14 at 2-clk bit duration, sel high, rx_ready = 1 -> rx_data sequence 1..14, rx_last = 1 only on 14, one frame_done pulse, frame_len = 14.
REQ-042 rx_ready = 0, 20-word frame, FIFO_DEPTH = 16 -> fifo_count = 16, overflow = 1, drained words 1..16, last word 16 with rx_last = 0.
REQ-043 Pulse ovf_clr during a dropping push -> overflow stays 1; pulse ovf_clr again with no push -> overflow = 0.
REQ-044 Assert rst mid-frame after 5 words, sel still low -> all outputs 0 immediately; remaining words of that frame are not captured; the next full frame of 3 words is received intact.
REQ-045 Full FIFO with simultaneous push and pop -> fifo_count stays 16, no overflow, order preserved.
REQ-046 sel pulses low then high with no spi_clk edge -> frame_done pulses once, fifo_count = 0, frame_len = 0.
